// File: rtl/sc_io_pkg.sv
// Shared constants and helpers for the sc_computer input-port block:
// register offsets within the I/O page, press-count width/saturation,
// and the address decoder used by the top level.
package sc_io_pkg;

    localparam logic [4:0] SC_IO_SW_OFF   = 5'h00;
    localparam logic [4:0] SC_IO_KEY_OFF  = 5'h04;
    localparam logic [4:0] SC_IO_EVT_OFF  = 5'h08;
    localparam logic [4:0] SC_IO_CNT_OFF  = 5'h0C;
    localparam logic [4:0] SC_IO_MASK_OFF = 5'h10;

    localparam int                    SC_IO_CNT_W   = 16;
    localparam logic [SC_IO_CNT_W-1:0] SC_IO_CNT_SAT = '1;

    typedef enum logic [2:0] {
        REG_SW,
        REG_KEY,
        REG_EVT,
        REG_CNT,
        REG_MASK,
        REG_NONE
    } reg_sel_e;

    // Word-aligned decode: the two byte-select bits never affect the target.
    function automatic reg_sel_e decode_addr(input logic [4:0] addr);
        logic [4:0] word;
        word = {addr[4:2], 2'b00};
        case (word)
            SC_IO_SW_OFF:   return REG_SW;
            SC_IO_KEY_OFF:  return REG_KEY;
            SC_IO_EVT_OFF:  return REG_EVT;
            SC_IO_CNT_OFF:  return REG_CNT;
            SC_IO_MASK_OFF: return REG_MASK;
            default:        return REG_NONE;
        endcase
    endfunction

    // Adds a small press increment and clamps at the all-ones value.
    function automatic logic [SC_IO_CNT_W-1:0] sat_add(
        input logic [SC_IO_CNT_W-1:0] base,
        input logic [3:0]             inc
    );
        logic [SC_IO_CNT_W:0] sum;
        sum = {1'b0, base} + {{(SC_IO_CNT_W-3){1'b0}}, inc};
        return sum[SC_IO_CNT_W] ? SC_IO_CNT_SAT : sum[SC_IO_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/sc_io_debounce.sv
// One-bit two-flop synchronizer followed by a stability counter. The
// stable level only follows the synchronized input after it has differed
// from stable for DEBOUNCE_CYCLES consecutive edges. 'change' is high in
// the cycle whose closing edge flips 'stable'.
module sc_io_debounce #(
    parameter int   DEBOUNCE_CYCLES = 1000000,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic change
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    assign change = (sync2 != stable) && (cnt == CNT_MAX);

    // Two-flop synchronizer for the asynchronous raw input.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            sync1 <= RESET_VAL;
            sync2 <= RESET_VAL;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Stability counter: any return to the stable level restarts the count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            stable <= RESET_VAL;
        end else if (sync2 == stable) begin
            cnt <= '0;
        end else if (change) begin
            stable <= sync2;
            cnt    <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sc_io_input_port.sv
// Memory-mapped input responder for the sc_computer I/O page: debounced
// switches and active-low keys, sticky key-press events, a saturating
// press counter, and registered one-cycle-latency read data.
// Optional build macro SC_IO_INPUT_IRQ_EN adds the MASK register at 0x10
// and a registered level interrupt; without it irq is tied low.
module sc_io_input_port
    import sc_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int NUM_SW          = 10,
    parameter int NUM_KEY         = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_SW-1:0] sw,
    input  logic [NUM_KEY-1:0] key,
    input  logic              io_sel,
    input  logic              io_rd,
    input  logic              io_wr,
    input  logic [4:0]        io_addr,
    input  logic [31:0]       io_wdata,
    output logic [31:0]       io_rdata,
    output logic              io_rvalid,
    output logic              irq
);

    logic [NUM_SW-1:0]      sw_stable;
    logic [NUM_SW-1:0]      sw_change_unused;   // switches raise no events
    logic [NUM_KEY-1:0]     key_stable;
    logic [NUM_KEY-1:0]     key_change;
    logic [NUM_KEY-1:0]     kp;
    logic [NUM_KEY-1:0]     press;
    logic [3:0]             press_cnt;
    logic [NUM_KEY-1:0]     evt;
    logic [NUM_KEY-1:0]     w1c;
    logic [SC_IO_CNT_W-1:0] count;
    logic [31:0]            rd_mux;
    logic                   wr_en;
    logic                   rd_en;
    reg_sel_e               addr_sel;
    logic                   unused_wdata;

`ifdef SC_IO_INPUT_IRQ_EN
    logic [NUM_KEY-1:0]     mask;
`endif

    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
        sc_io_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VAL       (1'b0)
        ) u_db (
            .clock  (clock),
            .reset  (reset),
            .raw    (sw[i]),
            .stable (sw_stable[i]),
            .change (sw_change_unused[i])
        );
    end

    for (genvar i = 0; i < NUM_KEY; i++) begin : g_key
        sc_io_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VAL       (1'b1)
        ) u_db (
            .clock  (clock),
            .reset  (reset),
            .raw    (key[i]),
            .stable (key_stable[i]),
            .change (key_change[i])
        );
    end

    // A press is a stable-level flip while the key is currently released.
    assign kp           = ~key_stable;
    assign press        = key_change & key_stable;
    assign wr_en        = io_sel & io_wr;
    assign rd_en        = io_sel & io_rd;
    assign addr_sel     = decode_addr(io_addr);
    assign w1c          = (wr_en && addr_sel == REG_EVT) ? io_wdata[NUM_KEY-1:0] : '0;
    assign unused_wdata = ^io_wdata[31:NUM_KEY];

    // Number of keys whose press lands on this edge.
    always_comb begin
        // NOTE: combinational outputs get a default first so no path can
        // leave them unassigned and infer a latch.
        press_cnt = '0;
        for (int i = 0; i < NUM_KEY; i++) begin
            press_cnt = press_cnt + 4'(press[i]);
        end
    end

    // Read-data multiplexer over the current (pre-edge) register values.
    always_comb begin
        rd_mux = '0;
        case (addr_sel)
            REG_SW:   rd_mux = 32'(sw_stable);
            REG_KEY:  rd_mux = 32'(kp);
            REG_EVT:  rd_mux = 32'(evt);
            REG_CNT:  rd_mux = 32'(count);
`ifdef SC_IO_INPUT_IRQ_EN
            REG_MASK: rd_mux = 32'(mask);
`endif
            default:  rd_mux = '0;
        endcase
    end

    // Sticky press events; a new press beats a same-cycle clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            evt <= '0;
        end else begin
            evt <= (evt & ~w1c) | press;
        end
    end

    // Saturating press counter; a software write zeroes it and wins.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (wr_en && addr_sel == REG_CNT) begin
            count <= '0;
        end else if (|press) begin
            count <= sat_add(count, press_cnt);
        end
    end

    // Registered read port: data held between reads, valid pulses once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            io_rdata  <= '0;
            io_rvalid <= 1'b0;
        end else begin
            io_rvalid <= rd_en;
            if (rd_en) begin
                io_rdata <= rd_mux;
            end
        end
    end

`ifdef SC_IO_INPUT_IRQ_EN
    // Interrupt mask register, writable by software.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mask <= '0;
        end else if (wr_en && addr_sel == REG_MASK) begin
            mask <= io_wdata[NUM_KEY-1:0];
        end
    end

    // Level interrupt, one edge behind the masked event state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            irq <= 1'b0;
        end else begin
            irq <= |(evt & mask);
        end
    end
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_sc_io_input_port.sv
// Directed bench for sc_io_input_port with DEBOUNCE_CYCLES=4.
// Honours SC_IO_INPUT_IRQ_EN to pick irq/MASK expectations.
module tb_sc_io_input_port;
    import sc_io_pkg::*;

    localparam int DB = 4;

`ifdef SC_IO_INPUT_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  sw = '0;
    logic [2:0]  key = 3'b111;
    logic        io_sel = 1'b0;
    logic        io_rd = 1'b0;
    logic        io_wr = 1'b0;
    logic [4:0]  io_addr = '0;
    logic [31:0] io_wdata = '0;
    logic [31:0] io_rdata;
    logic        io_rvalid;
    logic        irq;

    int checks = 0;
    int errors = 0;

    sc_io_input_port #(
        .DEBOUNCE_CYCLES (DB),
        .NUM_SW          (10),
        .NUM_KEY         (3)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .sw        (sw),
        .key       (key),
        .io_sel    (io_sel),
        .io_rd     (io_rd),
        .io_wr     (io_wr),
        .io_addr   (io_addr),
        .io_wdata  (io_wdata),
        .io_rdata  (io_rdata),
        .io_rvalid (io_rvalid),
        .irq       (irq)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        bit          sel;
        bit          rd;
        bit          wr;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic bus(input logic sel, input logic rd, input logic wr,
                       input logic [4:0] addr, input logic [31:0] wdata);
        io_sel   = sel;
        io_rd    = rd;
        io_wr    = wr;
        io_addr  = addr;
        io_wdata = wdata;
        @(posedge clock);
        #1;
        io_sel = 1'b0;
        io_rd  = 1'b0;
        io_wr  = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [4:0] addr, input logic [31:0] exp);
        bus(1'b1, 1'b1, 1'b0, addr, 32'h0);
        check(name, io_rdata, exp);
        check({name, "_rvalid"}, {31'b0, io_rvalid}, 32'h1);
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] data);
        bus(1'b1, 1'b0, 1'b1, addr, data);
    endtask

    function automatic vec_t mk(input string name, input bit sel, input bit rd, input bit wr_f,
                                input logic [4:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp);
        vec_t v;
        v.name = name; v.sel = sel; v.rd = rd; v.wr = wr_f;
        v.addr = addr; v.wdata = wdata; v.exp = exp;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Register-map sweep, applied while key[2] is held pressed.
        vecs[0]  = mk("tbl_key",        1, 1, 0, SC_IO_KEY_OFF, 32'h0,   32'h2);
        vecs[1]  = mk("tbl_evt",        1, 1, 0, SC_IO_EVT_OFF, 32'h0,   32'h2);
        vecs[2]  = mk("tbl_cnt",        1, 1, 0, SC_IO_CNT_OFF, 32'h0,   32'h1);
        vecs[3]  = mk("tbl_wr_sw_ro",   1, 0, 1, SC_IO_SW_OFF,  32'hFFF, 32'h0);
        vecs[4]  = mk("tbl_sw",         1, 1, 0, SC_IO_SW_OFF,  32'h0,   32'h2A5);
        vecs[5]  = mk("tbl_wr_nosel",   0, 0, 1, SC_IO_EVT_OFF, 32'h2,   32'h0);
        vecs[6]  = mk("tbl_evt_kept",   1, 1, 0, SC_IO_EVT_OFF, 32'h0,   32'h2);
        vecs[7]  = mk("tbl_evt_byteof", 1, 1, 0, 5'h0B,         32'h0,   32'h2);
        vecs[8]  = mk("tbl_unmap_14",   1, 1, 0, 5'h14,         32'h0,   32'h0);
        vecs[9]  = mk("tbl_unmap_1c",   1, 1, 0, 5'h1C,         32'h0,   32'h0);
        vecs[10] = mk("tbl_key_rdwr",   1, 1, 1, SC_IO_KEY_OFF, 32'hFFFF, 32'h2);
        vecs[11] = mk("tbl_mask_rst",   1, 1, 0, SC_IO_MASK_OFF, 32'h0,  32'h0);

        // Reset state.
        #1;
        check("rst_rdata", io_rdata, 32'h0);
        check("rst_rvalid", {31'b0, io_rvalid}, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        tick(2);
        reset = 1'b0;

        // Switch debounce latency.
        sw = 10'h2A5;
        rd_chk("sw_early", SC_IO_SW_OFF, 32'h0);
        tick(5);
        rd_chk("sw_settled", SC_IO_SW_OFF, 32'h2A5);
        tick(1);
        check("sw_rvalid_pulse", {31'b0, io_rvalid}, 32'h0);
        check("sw_rdata_hold", io_rdata, 32'h2A5);

        // Short glitch on key[1] never reaches stable.
        key = 3'b110;
        tick(3);
        key = 3'b111;
        tick(8);
        rd_chk("glitch_key", SC_IO_KEY_OFF, 32'h0);
        rd_chk("glitch_evt", SC_IO_EVT_OFF, 32'h0);
        rd_chk("glitch_cnt", SC_IO_CNT_OFF, 32'h0);

        // key[2] held: full press, then the register-map table.
        key = 3'b101;
        tick(6);
        for (int i = 0; i < 12; i++) begin
            bus(vecs[i].sel, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            if (vecs[i].sel && vecs[i].rd) begin
                check(vecs[i].name, io_rdata, vecs[i].exp);
                check({vecs[i].name, "_rvalid"}, {31'b0, io_rvalid}, 32'h1);
            end else begin
                check({vecs[i].name, "_norv"}, {31'b0, io_rvalid}, 32'h0);
            end
        end
        key = 3'b111;
        tick(8);
        rd_chk("rel_key", SC_IO_KEY_OFF, 32'h0);
        rd_chk("rel_evt_sticky", SC_IO_EVT_OFF, 32'h2);
        rd_chk("rel_cnt", SC_IO_CNT_OFF, 32'h1);
        wr(SC_IO_EVT_OFF, 32'h2);
        rd_chk("w1c_evt", SC_IO_EVT_OFF, 32'h0);

        // key[1] and key[3] together add two.
        key = 3'b010;
        tick(6);
        rd_chk("dual_cnt", SC_IO_CNT_OFF, 32'h3);
        rd_chk("dual_evt", SC_IO_EVT_OFF, 32'h5);
        key = 3'b111;
        tick(8);

        // Saturation from a preloaded count.
        force dut.count = 16'hFFFE;
        #1;
        release dut.count;
        key = 3'b010;
        tick(6);
        rd_chk("sat_cnt", SC_IO_CNT_OFF, 32'hFFFF);
        key = 3'b111;
        tick(8);
        wr(SC_IO_CNT_OFF, 32'h1234);
        rd_chk("cnt_clear", SC_IO_CNT_OFF, 32'h0);
        wr(SC_IO_EVT_OFF, 32'h7);
        rd_chk("evt_clear_all", SC_IO_EVT_OFF, 32'h0);

        // W1C on the same edge the key[1] event sets: set wins.
        key = 3'b110;
        tick(DB + 1);
        wr(SC_IO_EVT_OFF, 32'h1);
        rd_chk("set_beats_w1c", SC_IO_EVT_OFF, 32'h1);
        rd_chk("set_beats_cnt", SC_IO_CNT_OFF, 32'h1);
        key = 3'b111;
        tick(8);
        wr(SC_IO_EVT_OFF, 32'h1);

        // COUNT write on the same edge as a key[3] press: write wins.
        key = 3'b011;
        tick(DB + 1);
        wr(SC_IO_CNT_OFF, 32'h0);
        rd_chk("cnt_wr_beats_inc", SC_IO_CNT_OFF, 32'h0);
        // Read and W1C together: pre-write value returned, clear applied.
        bus(1'b1, 1'b1, 1'b1, SC_IO_EVT_OFF, 32'h4);
        check("rdwr_old_value", io_rdata, 32'h4);
        rd_chk("rdwr_cleared", SC_IO_EVT_OFF, 32'h0);
        key = 3'b111;
        tick(8);

        // Reset in the middle of a key[3] debounce.
        key = 3'b011;
        tick(4);
        reset = 1'b1;
        #1;
        check("midrst_rdata", io_rdata, 32'h0);
        check("midrst_rvalid", {31'b0, io_rvalid}, 32'h0);
        key = 3'b111;
        tick(2);
        reset = 1'b0;
        tick(10);
        rd_chk("midrst_evt", SC_IO_EVT_OFF, 32'h0);
        rd_chk("midrst_cnt", SC_IO_CNT_OFF, 32'h0);
        rd_chk("midrst_key", SC_IO_KEY_OFF, 32'h0);
        rd_chk("midrst_sw", SC_IO_SW_OFF, 32'h2A5);

        // Interrupt path (or its absence).
        wr(SC_IO_MASK_OFF, 32'h4);
        rd_chk("mask_read", SC_IO_MASK_OFF, IRQ_ON ? 32'h4 : 32'h0);
        key = 3'b011;
        tick(DB + 2);
        check("irq_same_edge", {31'b0, irq}, 32'h0);
        tick(1);
        check("irq_next_edge", {31'b0, irq}, {31'b0, IRQ_ON});
        key = 3'b010;
        tick(DB + 3);
        check("irq_unmasked_key", {31'b0, irq}, {31'b0, IRQ_ON});
        rd_chk("irq_evt", SC_IO_EVT_OFF, 32'h5);
        wr(SC_IO_EVT_OFF, 32'h4);
        check("irq_w1c_edge", {31'b0, irq}, {31'b0, IRQ_ON});
        tick(1);
        check("irq_dropped", {31'b0, irq}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sc_io_input_port.md
Name: sc_io_input_port

Overview:
- Memory-mapped input responder for the sc_computer I/O page. It is the device end of the switch/key stimulus path.
- Synchronizes and debounces board switches sw[9:0] and active-low keys key[3:1].
- Latches key-press events and a saturating press count.
- Returns register contents to CPU load accesses with one-cycle registered latency.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a new input level (20 ms at 50 MHz); must be >= 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES), width of each debounce counter.
- NUM_SW, 10, number of switch inputs.
- NUM_KEY, 3, number of key inputs.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- sw  in  NUM_SW  raw slide switches, level, asynchronous to clock.
- key  in  NUM_KEY  raw push keys, active-low (0 = pressed), asynchronous to clock.
- io_sel  in  1  CPU address decodes to this block's page.
- io_rd  in  1  load strobe.
- io_wr  in  1  store strobe.
- io_addr  in  5  byte offset within page; bits [1:0] ignored.
- io_wdata  in  32  store data.
- io_rdata  out  32  registered read data.
- io_rvalid  out  1  one-cycle pulse: io_rdata updated this cycle.
- irq  out  1  key-event interrupt; tied 0 unless IRQ_EN.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - io_rdata=0, io_rvalid=0, irq=0.
  - Switch synchronizers and stable levels = 0.
  - Key synchronizers and stable levels = released.
  - All debounce counters = 0.
  - Event flags = 0, press count = 0, mask = 0.
- Reset mid-debounce discards partial counts. No event may fire on reset release.
- Synchronizer: two flops per input. A raw change is visible in sync after 2 edges.
- Debounce, per bit:
  - sync == stable: counter <= 0.
  - sync != stable and counter < DEBOUNCE_CYCLES-1: counter++.
  - sync != stable and counter == DEBOUNCE_CYCLES-1: stable <= sync, counter <= 0.
  - Total latency from raw change to stable = 2 + DEBOUNCE_CYCLES edges.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never reaches stable.
- Key pressed level: kp[i] = ~stable_key[i].
- Event: on the same edge kp[i] goes 0->1, event[i] <= 1 (sticky).
  - Release (1->0) produces no event.
- Press count (16-bit): adds the number of keys pressing on that edge (0..3) and saturates at 0xFFFF.
- Register map (word offsets); unmapped offsets read 0:
  - 0x00 SW, R: {22'b0, sw_stable}.
  - 0x04 KEY, R: {29'b0, kp}.
  - 0x08 EVENT, R/W1C: {29'b0, event}. Write clears bits where io_wdata[i]=1.
  - 0x0C COUNT, R/W: {16'b0, count}. Any write sets count to 0.
  - 0x10 MASK, R/W, only with IRQ_EN: {29'b0, mask}.
- Read: io_sel&io_rd sampled at edge t.
  - io_rdata holds the register value as of before edge t, from edge t onward.
  - io_rvalid=1 for the cycle following t only.
  - io_rdata holds its value until the next read.
- Write: io_sel&io_wr applies at the edge.
  - Writes are ignored at RO offsets and when io_sel=0.
- Simultaneous events:
  - EVENT set and W1C on the same bit in the same cycle: set wins (bit stays 1).
  - Press increment and COUNT write on the same edge: count <= 0 (the increment is discarded).
  - io_rd and io_wr both asserted: read returns pre-write value, and the write takes effect.

Optional Feature:
- Macro SC_IO_INPUT_IRQ_EN.
- Defined:
  - MASK register exists at 0x10.
  - irq is a registered output: irq <= |(event & mask), asserted the edge after the qualifying event is set.
  - irq is level; it drops the edge after a W1C clears the last masked event.
- Undefined:
  - No mask storage; 0x10 reads 0 and writes are ignored.
  - irq is constant 0.

Decomposition:
- Package sc_io_pkg:
  - Offset constants SC_IO_SW_OFF=0x00, SC_IO_KEY_OFF=0x04, SC_IO_EVT_OFF=0x08, SC_IO_CNT_OFF=0x0C, SC_IO_MASK_OFF=0x10.
  - Press-count width 16 and saturation value.
- Sub-module sc_io_debounce: one bit with synchronizer + counter, parameter DEBOUNCE_CYCLES, outputs stable level.
  - Instantiated NUM_SW+NUM_KEY times via generate.
  - Reset value is set per instance by a RESET_VAL parameter: 0 for switches, 1 for keys.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset, then sw=0x2A5 held.
  - SW read before 6 edges returns 0x000.
  - SW read after 6 edges returns 0x2A5 with io_rvalid a single pulse.
- key[1] low for 3 cycles then high: KEY=0, EVENT=0, COUNT=0 (glitch rejected).
- key[2] low held.
  - After 6 edges: KEY=0x2, EVENT=0x2, COUNT=1.
  - Release, then read: EVENT still 0x2.
  - Write 0x2 to 0x08: EVENT=0.
- Press key[1] and key[3] simultaneously: COUNT increments by 2.
  - Preload near 0xFFFE via repeated presses or force: saturates at 0xFFFF.
  - Write 0x0C: COUNT=0.
- W1C on bit 0 in the same cycle key[1]'s event sets: EVENT bit 0 remains 1.
  - Assert reset mid-debounce of key[3]: no event after release of reset.
- With SC_IO_INPUT_IRQ_EN: MASK=0x4, press key[3].
  - irq=1 one edge after EVENT bit 2 sets.
  - Press key[1]: irq unchanged.
  - W1C 0x4: irq=0 next edge.
- Without the macro, the same stimulus leaves irq=0 and a 0x10 read returns 0.
